regfile_wb_sched: RTL

//  Writeback scheduler and scoreboard for the general register file (32 x XLEN).

---
 rtl/regfile_wb_sched.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and scoreboard for the 32-entry register file: round-robin
// arbitration of writeback sources onto the single write port, plus RAW/WAW issue stalls.
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = 5,
  parameter int NWB  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_issue_valid,
  input  logic [RAW-1:0]      i_issue_rs1,
  input  logic [RAW-1:0]      i_issue_rs2,
  input  logic [RAW-1:0]      i_issue_rd,
  input  logic                i_issue_rd_we,
  output logic                o_issue_stall,
  input  logic                i_flush,
  input  logic [NWB-1:0]      i_wb_valid,
  input  logic [NWB*RAW-1:0]  i_wb_rd,
  input  logic [NWB*XLEN-1:0] i_wb_data,
  output logic [NWB-1:0]      o_wb_ready,
  output logic                o_rf_w_enable,
  output logic [RAW-1:0]      o_rf_rd_num,
  output logic [XLEN-1:0]     o_rf_rd_data,
  output logic [RAW:0]        o_pending_cnt
);

  localparam int PW = (NWB > 1) ? $clog2(NWB) : 1;

  logic [NREG-1:0] r_pending;
  logic [PW-1:0]   r_rrPtr;
  logic            r_wEn;
  logic [RAW-1:0]  r_rdNum;
  logic [XLEN-1:0] r_rdData;
  logic [RAW:0]    r_cnt;

  logic            w_hazard;
  logic            w_issueFire;
  logic            w_anyGrant;
  logic [NWB-1:0]  w_grant;
  int              w_grantIdx;
  logic [RAW-1:0]  w_grantRd;
  logic [XLEN-1:0] w_grantData;
  logic [NREG-1:0] w_pendNext;
  logic [RAW:0]    w_cntNext;

  // No bypass: any pending source or destination holds the instruction, as does a flush.
  always_comb begin
    w_hazard = ((i_issue_rs1 != '0) && r_pending[i_issue_rs1])
            || ((i_issue_rs2 != '0) && r_pending[i_issue_rs2])
            || (i_issue_rd_we && (i_issue_rd != '0) && r_pending[i_issue_rd])
            || i_flush;
    o_issue_stall = !rst_n || (i_issue_valid && w_hazard);
    w_issueFire   = rst_n && i_issue_valid && !w_hazard;
  end

  always_comb begin
    w_grant     = '0;
    w_grantIdx  = 0;
    w_anyGrant  = 1'b0;
    w_grantRd   = '0;
    w_grantData = '0;
    if (rst_n) begin
      for (int k = 0; k < NWB; k++) begin
        if (!w_anyGrant && i_wb_valid[(int'(r_rrPtr) + k) % NWB]) begin
          w_anyGrant = 1'b1;
          w_grantIdx = (int'(r_rrPtr) + k) % NWB;
        end
      end
      if (w_anyGrant) begin
        w_grant[w_grantIdx] = 1'b1;
        w_grantRd   = i_wb_rd[w_grantIdx*RAW +: RAW];
        w_grantData = i_wb_data[w_grantIdx*XLEN +: XLEN];
      end
    end
  end

  assign o_wb_ready = w_grant;

  // Set is applied after clear so a newly issued writer keeps ownership of rd.
  always_comb begin
    w_pendNext = r_pending;
    if (r_wEn) begin
      w_pendNext[r_rdNum] = 1'b0;
    end
    if (w_issueFire && i_issue_rd_we && (i_issue_rd != '0)) begin
      w_pendNext[i_issue_rd] = 1'b1;
    end
    if (i_flush) begin
      w_pendNext = '0;
    end
    w_pendNext[0] = 1'b0;
    w_cntNext = '0;
    for (int i = 0; i < NREG; i++) begin
      w_cntNext = w_cntNext + {{RAW{1'b0}}, w_pendNext[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_cnt     <= '0;
      r_rrPtr   <= '0;
      r_wEn     <= 1'b0;
      r_rdNum   <= '0;
      r_rdData  <= '0;
    end else begin
      r_pending <= w_pendNext;
      r_cnt     <= w_cntNext;
      r_wEn     <= w_anyGrant && (w_grantRd != '0);
      if (w_anyGrant) begin
        r_rrPtr  <= PW'((w_grantIdx + 1) % NWB);
        r_rdNum  <= w_grantRd;
        r_rdData <= w_grantData;
      end
    end
  end

  assign o_rf_w_enable = r_wEn;
  assign o_rf_rd_num   = r_rdNum;
  assign o_rf_rd_data  = r_rdData;
  assign o_pending_cnt = r_cnt;

endmodule
